// File: rtl/load_store_unit_pkg.sv
// ============================================================================
// Module   : load_store_unit_pkg
// Purpose  : Shared types for the load/store unit (funct3 codes, LSU states).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package load_store_unit_pkg;

   localparam int DATA_ADDR_WIDTH = 32;
   localparam int BYTE_EN_WIDTH   = 4;

   typedef enum logic [2:0] {
      MEM_F3_B  = 3'b000,
      MEM_F3_H  = 3'b001,
      MEM_F3_W  = 3'b010,
      MEM_F3_BU = 3'b100,
      MEM_F3_HU = 3'b101
   } mem_funct3_e;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_WAIT = 2'd2,
      LSU_DONE = 2'd3
   } lsu_state_e;

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module   : lsu_align
// Purpose  : Byte-lane steering, load extraction/extension and fault check.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
   import load_store_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                     i_is_load,
   input  logic [2:0]               i_funct3,
   input  logic [1:0]               i_ea_lo,
   input  logic [DATA_WIDTH-1:0]    i_store_data,
   input  logic [DATA_WIDTH-1:0]    i_load_word,
   output logic [BYTE_EN_WIDTH-1:0] o_be,
   output logic [DATA_WIDTH-1:0]    o_wdata,
   output logic [DATA_WIDTH-1:0]    o_load_data,
   output logic                     o_fault
);

   logic [DATA_WIDTH-1:0] w_shift;

   assign w_shift = i_load_word >> {i_ea_lo, 3'b000};

   always_comb begin
      o_be        = 4'b1111;
      o_wdata     = '0;
      o_load_data = '0;
      o_fault     = 1'b0;
      if (i_is_load) begin
         case (i_funct3)
            MEM_F3_B:  o_load_data = {{(DATA_WIDTH-8){w_shift[7]}}, w_shift[7:0]};
            MEM_F3_BU: o_load_data = {{(DATA_WIDTH-8){1'b0}}, w_shift[7:0]};
            MEM_F3_H: begin
               o_load_data = {{(DATA_WIDTH-16){w_shift[15]}}, w_shift[15:0]};
               o_fault     = i_ea_lo[0];
            end
            MEM_F3_HU: begin
               o_load_data = {{(DATA_WIDTH-16){1'b0}}, w_shift[15:0]};
               o_fault     = i_ea_lo[0];
            end
            MEM_F3_W: begin
               o_load_data = w_shift;
               o_fault     = |i_ea_lo;
            end
            default:   o_fault = 1'b1;
         endcase
      end else begin
         // Sub-word stores replicate the datum so any enabled lane carries it.
         case (i_funct3)
            MEM_F3_B: begin
               o_be    = 4'b0001 << i_ea_lo;
               o_wdata = {4{i_store_data[7:0]}};
            end
            MEM_F3_H: begin
               o_be    = 4'b0011 << i_ea_lo;
               o_wdata = {2{i_store_data[15:0]}};
               o_fault = i_ea_lo[0];
            end
            MEM_F3_W: begin
               o_wdata = i_store_data;
               o_fault = |i_ea_lo;
            end
            default:  o_fault = 1'b1;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module   : load_store_unit
// Purpose  : Memory-access stage: address generation, memory handshake, result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = DATA_ADDR_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_req_valid,
   output logic                     o_req_ready,
   input  logic                     i_is_load,
   input  logic                     i_is_store,
   input  logic [2:0]               i_funct3,
   input  logic [DATA_WIDTH-1:0]    i_base,
   input  logic [31:0]              i_offset,
   input  logic [DATA_WIDTH-1:0]    i_store_data,
   output logic                     o_mem_req_valid,
   input  logic                     i_mem_req_ready,
   output logic                     o_mem_we,
   output logic [ADDR_WIDTH-1:0]    o_mem_addr,
   output logic [BYTE_EN_WIDTH-1:0] o_mem_be,
   output logic [DATA_WIDTH-1:0]    o_mem_wdata,
   input  logic                     i_mem_rsp_valid,
   input  logic [DATA_WIDTH-1:0]    i_mem_rdata,
   output logic                     o_rsp_valid,
   output logic [DATA_WIDTH-1:0]    o_rsp_data,
   output logic                     o_rsp_fault,
   output logic                     o_busy
);

   lsu_state_e r_state;
   lsu_state_e w_next;

   logic                     r_is_load;
   logic [2:0]               r_funct3;
   logic [1:0]               r_ea_lo;
   logic [ADDR_WIDTH-1:0]    r_mem_addr;
   logic [BYTE_EN_WIDTH-1:0] r_mem_be;
   logic [DATA_WIDTH-1:0]    r_mem_wdata;
   logic                     r_mem_we;
   logic [DATA_WIDTH-1:0]    r_rsp_data;
   logic                     r_rsp_fault;

   logic [31:0]              w_ea;
   logic                     w_idle;
   logic                     w_accept;
   logic                     w_al_load;
   logic [2:0]               w_al_funct3;
   logic [1:0]               w_al_ea_lo;
   logic [BYTE_EN_WIDTH-1:0] w_be;
   logic [DATA_WIDTH-1:0]    w_wdata;
   logic [DATA_WIDTH-1:0]    w_load_data;
   logic                     w_fault;

   assign w_ea     = i_base + i_offset;
   assign w_idle   = (r_state == LSU_IDLE);
   assign w_accept = w_idle && i_req_valid && (i_is_load || i_is_store);

   // The aligner sees live request fields while idle and the latched ones afterwards.
   assign w_al_load   = w_idle ? i_is_load : r_is_load;
   assign w_al_funct3 = w_idle ? i_funct3  : r_funct3;
   assign w_al_ea_lo  = w_idle ? w_ea[1:0] : r_ea_lo;

   lsu_align #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_align (
      .i_is_load    (w_al_load),
      .i_funct3     (w_al_funct3),
      .i_ea_lo      (w_al_ea_lo),
      .i_store_data (i_store_data),
      .i_load_word  (i_mem_rdata),
      .o_be         (w_be),
      .o_wdata      (w_wdata),
      .o_load_data  (w_load_data),
      .o_fault      (w_fault)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= LSU_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         LSU_IDLE: if (w_accept)        w_next = w_fault ? LSU_DONE : LSU_REQ;
         LSU_REQ:  if (i_mem_req_ready) w_next = r_is_load ? LSU_WAIT : LSU_DONE;
         LSU_WAIT: if (i_mem_rsp_valid) w_next = LSU_DONE;
         LSU_DONE:                      w_next = LSU_IDLE;
         default:                       w_next = LSU_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_is_load   <= 1'b0;
         r_funct3    <= 3'b000;
         r_ea_lo     <= 2'b00;
         r_mem_addr  <= '0;
         r_mem_be    <= '0;
         r_mem_wdata <= '0;
         r_mem_we    <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_fault <= 1'b0;
      end else if (w_accept) begin
         r_is_load   <= i_is_load;
         r_funct3    <= i_funct3;
         r_ea_lo     <= w_ea[1:0];
         r_mem_addr  <= {w_ea[ADDR_WIDTH-1:2], 2'b00};
         r_mem_be    <= w_be;
         r_mem_wdata <= w_wdata;
         r_mem_we    <= ~i_is_load;
         r_rsp_data  <= '0;
         r_rsp_fault <= w_fault;
      end else if ((r_state == LSU_WAIT) && i_mem_rsp_valid) begin
         r_rsp_data  <= w_load_data;
      end
   end

   assign o_req_ready     = w_idle;
   assign o_busy          = ~w_idle;
   assign o_mem_req_valid = (r_state == LSU_REQ);
   assign o_mem_we        = r_mem_we;
   assign o_mem_addr      = r_mem_addr;
   assign o_mem_be        = r_mem_be;
   assign o_mem_wdata     = r_mem_wdata;
   assign o_rsp_valid     = (r_state == LSU_DONE);
   assign o_rsp_fault     = (r_state == LSU_DONE) && r_rsp_fault;
   assign o_rsp_data      = (r_state == LSU_DONE) ? r_rsp_data : '0;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed and random checks of load_store_unit against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, is_load, is_store;
   logic [2:0]  funct3;
   logic [31:0] base, offset, store_data;
   logic        mem_req_valid, mem_req_ready, mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_rsp_valid;
   logic [31:0] mem_rdata;
   logic        rsp_valid, rsp_fault, busy;
   logic [31:0] rsp_data;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_req_valid     (req_valid),
      .o_req_ready     (req_ready),
      .i_is_load       (is_load),
      .i_is_store      (is_store),
      .i_funct3        (funct3),
      .i_base          (base),
      .i_offset        (offset),
      .i_store_data    (store_data),
      .o_mem_req_valid (mem_req_valid),
      .i_mem_req_ready (mem_req_ready),
      .o_mem_we        (mem_we),
      .o_mem_addr      (mem_addr),
      .o_mem_be        (mem_be),
      .o_mem_wdata     (mem_wdata),
      .i_mem_rsp_valid (mem_rsp_valid),
      .i_mem_rdata     (mem_rdata),
      .o_rsp_valid     (rsp_valid),
      .o_rsp_data      (rsp_data),
      .o_rsp_fault     (rsp_fault),
      .o_busy          (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reference: access size from funct3, alignment by modulo, lanes by byte index.
   function automatic void model(input bit ld, input logic [2:0] f3, input logic [31:0] ea,
                                 input logic [31:0] sd, input logic [31:0] rd,
                                 output bit flt, output logic [3:0] be,
                                 output logic [31:0] wd, output logic [31:0] res);
      int     size;
      int     off;
      bit     legal;
      longint v;
      int     be_i;
      size  = 1 << (int'(f3) % 4);
      off   = int'(ea % 4);
      legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
      flt   = !legal || ((ea % size) != 0);
      be_i  = ((1 << size) - 1) << off;
      be    = ld ? 4'hF : be_i[3:0];
      wd    = '0;
      for (int i = 0; i < 4; i++) wd[8*i +: 8] = sd[8*(i % size) +: 8];
      v = longint'(rd >> (8 * off));
      if (size < 4) begin
         v = v % (longint'(1) << (8 * size));
         if (f3 < 3'd4 && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
      end
      res = (ld && !flt) ? v[31:0] : 32'h0;
   endfunction

   task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                         input logic [31:0] b, input logic [31:0] off, input logic [31:0] sd,
                         input logic [31:0] rd, input int rdy_wait, input int rsp_wait);
      bit          flt, eff_ld, mem_exp, in_req, in_wait;
      logic [3:0]  be;
      logic [31:0] wd, res, ea;
      int          rsp_cyc;
      eff_ld = ld;
      ea     = b + off;
      model(eff_ld, f3, ea, sd, rd, flt, be, wd, res);
      cyc();
      req_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3;
      base = b; offset = off; store_data = sd;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = $urandom;
      @(negedge clk);
      chk("accept_req_ready", 32'(req_ready), 32'd1);
      if (!ld && !st) begin
         cyc();
         req_valid = 1'b0;
         @(negedge clk);
         chk("ignored_busy", 32'(busy), 32'd0);
         chk("ignored_memreq", 32'(mem_req_valid), 32'd0);
         return;
      end
      rsp_cyc = flt ? 1 : (!eff_ld ? 2 + rdy_wait : 3 + rdy_wait + rsp_wait);
      for (int c = 1; c <= rsp_cyc + 1; c++) begin
         cyc();
         req_valid  = (c <= rsp_cyc) ? 1'($urandom % 2) : 1'b0;
         is_load    = 1'($urandom); is_store = 1'($urandom); funct3 = 3'($urandom);
         base       = $urandom; offset = $urandom; store_data = $urandom;
         in_req     = !flt && c <= 1 + rdy_wait;
         in_wait    = eff_ld && !flt && c >= 2 + rdy_wait && c <= 2 + rdy_wait + rsp_wait;
         mem_req_ready = in_req ? (c == 1 + rdy_wait) : 1'($urandom % 2);
         mem_rsp_valid = in_wait ? (c == 2 + rdy_wait + rsp_wait) : 1'($urandom % 2);
         mem_rdata     = (in_wait && c == 2 + rdy_wait + rsp_wait) ? rd : $urandom;
         @(negedge clk);
         if (c <= rsp_cyc) begin
            mem_exp = in_req;
            chk("mem_req_valid", 32'(mem_req_valid), 32'(mem_exp));
            if (mem_exp) begin
               chk("mem_addr", mem_addr, ea & 32'hFFFF_FFFC);
               chk("mem_be", 32'(mem_be), 32'(be));
               chk("mem_we", 32'(mem_we), 32'(!eff_ld));
               if (!eff_ld) chk("mem_wdata", mem_wdata, wd);
            end
            chk("busy_active", 32'(busy), 32'd1);
            chk("req_ready_active", 32'(req_ready), 32'd0);
            chk("rsp_valid", 32'(rsp_valid), 32'(c == rsp_cyc));
            if (c == rsp_cyc) begin
               chk("rsp_data", rsp_data, res);
               chk("rsp_fault", 32'(rsp_fault), 32'(flt));
            end
         end else begin
            chk("rsp_valid_after", 32'(rsp_valid), 32'd0);
            chk("busy_after", 32'(busy), 32'd0);
            chk("req_ready_after", 32'(req_ready), 32'd1);
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_mem_req_valid"}, 32'(mem_req_valid), 32'd0);
      chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
      chk({tag, "_mem_addr"}, mem_addr, 32'd0);
      chk({tag, "_mem_be"}, 32'(mem_be), 32'd0);
      chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_rsp_data"}, rsp_data, 32'd0);
      chk({tag, "_rsp_fault"}, 32'(rsp_fault), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'd0;
      base = '0; offset = '0; store_data = '0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
      #12;
      check_reset_outputs("reset");
      #10 rst_n = 1'b1;

      run_op(1, 0, 3'b010, 32'h100, 32'd4, 32'h0, 32'hDEAD_BEEF, 0, 0);        // LW
      run_op(1, 0, 3'b000, 32'h100, 32'd3, 32'h0, 32'h80FF_FF00, 0, 0);        // LB
      run_op(1, 0, 3'b100, 32'h100, 32'd3, 32'h0, 32'h80FF_FF00, 0, 0);        // LBU
      run_op(1, 0, 3'b001, 32'h100, 32'd2, 32'h0, 32'h8001_7FFF, 1, 2);        // LH upper
      run_op(1, 0, 3'b101, 32'h200, 32'hFFFF_FFFE, 32'h0, 32'hF00D_ABCD, 0, 1); // LHU, negative offset
      run_op(0, 1, 3'b001, 32'h100, 32'd2, 32'h1234_ABCD, 32'h0, 0, 0);        // SH
      run_op(0, 1, 3'b000, 32'h100, 32'd1, 32'h0000_005A, 32'h0, 0, 0);        // SB
      run_op(0, 1, 3'b010, 32'h100, 32'd1, 32'h1111_2222, 32'h0, 0, 0);        // SW misaligned
      run_op(1, 0, 3'b010, 32'h300, 32'd8, 32'h0, 32'h0BAD_F00D, 5, 0);        // backpressure load
      run_op(0, 1, 3'b010, 32'h300, 32'd0, 32'hCAFE_0001, 32'h0, 5, 0);        // backpressure store
      run_op(1, 1, 3'b000, 32'h100, 32'd1, 32'h0, 32'h0000_7F00, 0, 0);        // both flags -> load
      run_op(0, 0, 3'b010, 32'h100, 32'd0, 32'h0, 32'h0, 0, 0);                // neither flag
      run_op(1, 0, 3'b011, 32'h100, 32'd0, 32'h0, 32'h0, 0, 0);                // illegal load funct3
      run_op(0, 1, 3'b100, 32'h100, 32'd0, 32'h0, 32'h0, 0, 0);                // illegal store funct3
      run_op(1, 0, 3'b001, 32'h100, 32'd1, 32'h0, 32'h0, 0, 0);                // LH misaligned

      for (int i = 0; i < 150; i++) begin
         bit ld, st;
         ld = 1'($urandom);
         st = ld ? 1'($urandom) : ($urandom % 4 != 0);
         run_op(ld, st, 3'($urandom), $urandom, ($urandom % 2) ? 32'($urandom_range(0, 15)) : $urandom,
                $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
      end

      // Reset while waiting for load data.
      cyc();
      req_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010;
      base = 32'h400; offset = 32'd0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      cyc();
      req_valid = 1'b0; mem_req_ready = 1'b1;
      cyc();
      mem_req_ready = 1'b0;
      @(negedge clk);
      chk("wait_busy", 32'(busy), 32'd1);
      chk("wait_memreq", 32'(mem_req_valid), 32'd0);
      cyc();
      #1 rst_n = 1'b0;
      #1 check_reset_outputs("midreset");
      #2 rst_n = 1'b1;
      cyc();
      mem_rsp_valid = 1'b1; mem_rdata = 32'h1234_5678;
      @(negedge clk);
      chk("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("post_reset_busy", 32'(busy), 32'd0);
      cyc();
      mem_rsp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_reset_idle", 32'(rsp_valid), 32'd0);
      end
      run_op(1, 0, 3'b000, 32'h400, 32'd2, 32'h0, 32'h00A5_0000, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage of the RISC-V core, directly downstream of the instruction decoder. It consumes the decoder's load/store fields (isLoad, isStore, funct3, constant) plus the register operands. It computes the effective address, runs a valid/ready handshake to data memory with byte enables, and returns a sign- or zero-extended load result or store completion to the writeback/control logic. The core stalls while busy is high.

Parameters:
DATA_WIDTH, 32, data word width; fixed at 32 because byte-lane logic assumes 4 lanes.
ADDR_WIDTH, DATA_ADDR_WIDTH from the basic types package, data address width.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous, active-low reset.
reqValid  in  1  decoded load/store presented.
reqReady  out  1  unit can accept a request.
isLoad  in  1  OpInfo.isLoad.
isStore  in  1  OpInfo.isStore.
funct3  in  3  OpInfo.funct3, interpreted as MemFunct3.
base  in  DATA_WIDTH  rs1 value.
offset  in  32  OpInfo.constant, already sign-extended immediate.
storeData  in  DATA_WIDTH  rs2 value.
memReqValid  out  1  memory request valid.
memReqReady  in  1  memory accepts request.
memWe  out  1  1 = write.
memAddr  out  ADDR_WIDTH  word-aligned address; low 2 bits are 0.
memBe  out  4  byte enables.
memWData  out  DATA_WIDTH  lane-steered store data.
memRspValid  in  1  load data valid.
memRData  in  DATA_WIDTH  raw load word.
rspValid  out  1  one-cycle completion pulse.
rspData  out  DATA_WIDTH  extended load result; 0 for stores and faults.
rspFault  out  1  qualifies rspValid: misaligned access or illegal funct3.
busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs 0 except reqReady=1. Registered address, data and byte enables are cleared.
- States and transitions:
  - IDLE: reqReady=1. When reqValid and (isLoad or isStore), the request is latched and the unit goes to REQ, or to DONE on fault. reqValid with neither flag set is ignored.
  - REQ: memReqValid=1 and memReqValid holds until memReqReady. On the handshake, a load goes to WAIT and a store goes to DONE.
  - WAIT: memRspValid is sampled only in this state. When it is seen, the extracted result is captured and the unit goes to DONE.
  - DONE: rspValid=1 for exactly one cycle, then IDLE. A new request can be accepted the cycle after DONE.
- Effective address: ea = base + offset, modulo 2^32, then truncated to ADDR_WIDTH. memAddr = {ea[ADDR_WIDTH-1:2], 2'b00}.
- Fault conditions:
  - Halfword access with ea[0]=1.
  - Word access with ea[1:0]!=0.
  - Load funct3 in {011, 110, 111}.
  - Store funct3 not in {000, 001, 010}.
  - A faulting request makes no memory access; rspFault=1 during DONE.
- Store steering:
  - SB: memBe = 4'b0001 << ea[1:0]; the byte is replicated on all lanes.
  - SH: memBe = 4'b0011 << ea[1:0]; the halfword is replicated.
  - SW: memBe = 4'b1111.
  - Loads drive memBe=4'b1111 and memWe=0.
- Load extraction: word shifted right by 8*ea[1:0], then:
  - LB/LH: sign-extended.
  - LBU/LHU: zero-extended.
  - LW: passed through.
- Latency from the accept cycle T:
  - Load: memReqValid at T+1; earliest rspValid at T+3 (memReqReady at T+1, memRspValid at T+2).
  - Store: earliest rspValid at T+2.
  - Fault: rspValid at T+1.
- memReqValid, memAddr, memBe, memWData and memWe are registered and stable throughout REQ.
- If both isLoad and isStore are set, the request is treated as a load.
- Inputs are don't-care outside the IDLE accept cycle.
- Reset mid-operation aborts immediately. A memRspValid arriving after reset is ignored because the unit is in IDLE.

Decomposition:
- Add to the shared Types package:
  - LsuState enum: IDLE, REQ, WAIT, DONE.
  - BYTE_EN_WIDTH = 4.
- Reuse the existing MemFunct3 enum.
- Sub-module lsu_align (purely combinational):
  - Inputs: funct3 and ea[1:0].
  - Outputs: memBe, steered store data, extracted/extended load data, fault flag.
  - The top level holds the FSM and registers.

Test Plan:
- LW: base=0x100, offset=4, memReqReady=1 at T+1, memRData=0xDEADBEEF at T+2 -> memAddr=0x104, memBe=1111, rspValid at T+3 with rspData=0xDEADBEEF, rspFault=0.
- LB/LBU with ea=0x103 and memRData=0x80FF_FF00 -> LB gives rspData=0xFFFFFF80; LBU gives 0x00000080.
- SH: ea=0x102, storeData=0x1234ABCD -> memBe=1100, memWData=0xABCDABCD, memWe=1, rspValid at T+2 with rspData=0.
- SW at ea=0x101 -> no memReqValid, rspValid+rspFault at T+1, busy high for exactly one cycle.
- Backpressure: memReqReady held 0 for 5 cycles -> memReqValid and memAddr stable, reqReady=0 and busy=1 throughout.
- rst deasserted-to-0 during WAIT, then memRspValid pulsed -> outputs 0 immediately, no rspValid after reset release.
